// File: rtl/jtsdram_unshuffle.sv
// Read-side unshuffler: recovers the reference word from a scrambled SDRAM read beat,
// compares it with the expected word and keeps mismatch statistics. Two-stage pipeline, no backpressure.
module jtsdram_unshuffle (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_ld,
   input  logic [4:0]  key_in,
   input  logic        clr,
   input  logic        rd_valid,
   input  logic [21:0] rd_addr,
   input  logic [15:0] rd_data,
   input  logic [15:0] exp_data,
   output logic [15:0] dout,
   output logic        dout_valid,
   output logic        mismatch,
   output logic [15:0] err_cnt,
   output logic        err_sticky,
   output logic [21:0] first_addr,
   output logic [15:0] first_got
);

   logic [4:0]  key_q;
   logic        v1_q;
   logic [21:0] a1_q;
   logic [15:0] dat1_q;
   logic [15:0] exp1_q;
   logic [4:0]  k1_q;
   logic [3:0]  p1_q;
   logic [3:0]  p_d;

   logic        v2_q;
   logic [21:0] a2_q;
   logic [15:0] dout_q;
   logic [15:0] dout_d;
   logic        mis_q;
   logic        mis_d;

   logic [15:0] cnt_q;
   logic        sticky_q;
   logic [21:0] faddr_q;
   logic [15:0] fgot_q;

   function automatic logic [3:0] swap4(input logic [3:0] x);
      return {x[2], x[0], x[3], x[1]};
   endfunction

   function automatic logic [3:0] unswap4(input logic [3:0] x);
      return {x[1], x[3], x[0], x[2]};
   endfunction

   // Physical nibble uses the key register as it stands when the beat is accepted.
   always_comb begin
      p_d = key_q[0] ? rd_addr[16:13] : rd_addr[3:0];
      if (key_q[1]) p_d = swap4(p_d);
      if (key_q[3]) p_d = p_d ^ 4'h5;
      if (key_q[4]) p_d = p_d ^ 4'hA;
   end

   always_comb begin
      dout_d = dat1_q;
      if (k1_q[4])           dout_d = dout_d ^ 16'hAAAA;
      if (k1_q[3] ^ p1_q[3]) dout_d = dout_d ^ 16'h5555;
      if (k1_q[2] ^ p1_q[2]) dout_d = {unswap4(dout_d[15:12]), unswap4(dout_d[11:8]), dout_d[7:0]};
      if (k1_q[1] ^ p1_q[1]) dout_d = {dout_d[15:8], unswap4(dout_d[7:4]), unswap4(dout_d[3:0])};
      if (k1_q[0] ^ p1_q[0]) dout_d = {dout_d[7:0], dout_d[15:8]};
      mis_d = (dout_d != exp1_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_q    <= '0;
         v1_q     <= 1'b0;
         a1_q     <= '0;
         dat1_q   <= '0;
         exp1_q   <= '0;
         k1_q     <= '0;
         p1_q     <= '0;
         v2_q     <= 1'b0;
         a2_q     <= '0;
         dout_q   <= '0;
         mis_q    <= 1'b0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         faddr_q  <= '0;
         fgot_q   <= '0;
      end else begin
         if (key_ld) key_q <= key_in;

         v1_q <= rd_valid;
         if (rd_valid) begin
            a1_q   <= rd_addr;
            dat1_q <= rd_data;
            exp1_q <= exp_data;
            k1_q   <= key_q;
            p1_q   <= p_d;
         end

         v2_q <= v1_q;
         if (v1_q) begin
            dout_q <= dout_d;
            mis_q  <= mis_d;
            a2_q   <= a1_q;
         end

         // clr wins over a mismatch retiring in the same cycle.
         if (clr) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            faddr_q  <= '0;
            fgot_q   <= '0;
         end else if (v2_q && mis_q) begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            if (!sticky_q) begin
               sticky_q <= 1'b1;
               faddr_q  <= a2_q;
               fgot_q   <= dout_q;
            end
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = v2_q;
   assign mismatch   = mis_q;
   assign err_cnt    = cnt_q;
   assign err_sticky = sticky_q;
   assign first_addr = faddr_q;
   assign first_got  = fgot_q;

endmodule

// File: tb/tb_jtsdram_unshuffle.sv
// Bench for jtsdram_unshuffle: directed and random beats checked against a rule-level model.
module tb_jtsdram_unshuffle;

   logic        clk;
   logic        rst_n;
   logic        key_ld;
   logic [4:0]  key_in;
   logic        clr;
   logic        rd_valid;
   logic [21:0] rd_addr;
   logic [15:0] rd_data;
   logic [15:0] exp_data;
   logic [15:0] dout;
   logic        dout_valid;
   logic        mismatch;
   logic [15:0] err_cnt;
   logic        err_sticky;
   logic [21:0] first_addr;
   logic [15:0] first_got;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [15:0] q_d[$];
   logic        q_m[$];
   int          q_c[$];

   jtsdram_unshuffle dut (
      .clk(clk), .rst_n(rst_n), .key_ld(key_ld), .key_in(key_in), .clr(clr),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .exp_data(exp_data),
      .dout(dout), .dout_valid(dout_valid), .mismatch(mismatch), .err_cnt(err_cnt),
      .err_sticky(err_sticky), .first_addr(first_addr), .first_got(first_got)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   // Reference model, written from the address/data rules
   function automatic logic [3:0] m_swap(input logic [3:0] x);
      return {x[2], x[0], x[3], x[1]};
   endfunction

   function automatic logic [3:0] m_unswap(input logic [3:0] x);
      logic [3:0] r;
      r = 4'h0;
      for (int y = 0; y < 16; y++)
         if (m_swap(4'(y)) == x) r = 4'(y);
      return r;
   endfunction

   function automatic logic [3:0] m_phys(input logic [4:0] k, input logic [21:0] a);
      logic [3:0] n;
      n = k[0] ? a[16:13] : a[3:0];
      if (k[1]) n = m_swap(n);
      if (k[3]) n = n ^ 4'h5;
      if (k[4]) n = n ^ 4'hA;
      return n;
   endfunction

   function automatic logic [15:0] m_desc(input logic [4:0] k, input logic [21:0] a, input logic [15:0] w);
      logic [3:0]  p;
      logic [15:0] d;
      p = m_phys(k, a);
      d = w;
      if (k[4]) d = d ^ 16'hAAAA;
      if (k[3] ^ p[3]) d = d ^ 16'h5555;
      if (k[2] ^ p[2]) begin d[15:12] = m_unswap(d[15:12]); d[11:8] = m_unswap(d[11:8]); end
      if (k[1] ^ p[1]) begin d[7:4] = m_unswap(d[7:4]); d[3:0] = m_unswap(d[3:0]); end
      if (k[0] ^ p[0]) d = {d[7:0], d[15:8]};
      return d;
   endfunction

   // Write-side scrambler: the same steps undone in reverse order
   function automatic logic [15:0] m_scr(input logic [4:0] k, input logic [21:0] a, input logic [15:0] w);
      logic [3:0]  p;
      logic [15:0] d;
      p = m_phys(k, a);
      d = w;
      if (k[0] ^ p[0]) d = {d[7:0], d[15:8]};
      if (k[1] ^ p[1]) begin d[7:4] = m_swap(d[7:4]); d[3:0] = m_swap(d[3:0]); end
      if (k[2] ^ p[2]) begin d[15:12] = m_swap(d[15:12]); d[11:8] = m_swap(d[11:8]); end
      if (k[3] ^ p[3]) d = d ^ 16'h5555;
      if (k[4]) d = d ^ 16'hAAAA;
      return d;
   endfunction

   // Every dout_valid must match the oldest outstanding beat, two cycles after issue
   always @(negedge clk) begin
      if (dout_valid === 1'b1) begin
         if (q_d.size() == 0) begin
            chk("unexpected_dout_valid", {31'd0, dout_valid}, 32'd0);
         end else begin
            chk("dout", {16'd0, dout}, {16'd0, q_d[0]});
            chk("mismatch", {31'd0, mismatch}, {31'd0, q_m[0]});
            chk("latency", cyc - q_c[0], 32'd2);
            void'(q_d.pop_front());
            void'(q_m.pop_front());
            void'(q_c.pop_front());
         end
      end
   end

   logic [4:0] cur_k;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         rd_valid = 1'b0;
         key_ld   = 1'b0;
         clr      = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic set_key(input logic [4:0] k);
      key_ld = 1'b1;
      key_in = k;
      rd_valid = 1'b0;
      @(negedge clk);
      key_ld = 1'b0;
      cur_k = k;
   endtask

   task automatic send(input logic [21:0] a, input logic [15:0] rd, input logic [15:0] ex,
                       input logic [15:0] want_d, input logic want_m);
      rd_valid = 1'b1;
      rd_addr  = a;
      rd_data  = rd;
      exp_data = ex;
      q_d.push_back(want_d);
      q_m.push_back(want_m);
      q_c.push_back(cyc);
      @(negedge clk);
   endtask

   initial begin
      logic [21:0] a;
      logic [15:0] w;
      logic [15:0] d;
      logic [4:0]  kn;
      logic [21:0] fa;
      logic [15:0] fg;
      int          nv;

      rst_n = 1'b0; key_ld = 1'b0; key_in = '0; clr = 1'b0;
      rd_valid = 1'b0; rd_addr = '0; rd_data = '0; exp_data = '0;
      cur_k = '0;
      repeat (3) @(negedge clk);
      chk("rst_dout", {16'd0, dout}, 32'd0);
      chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
      chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
      chk("rst_first_addr", {10'd0, first_addr}, 32'd0);
      chk("rst_first_got", {16'd0, first_got}, 32'd0);
      rst_n = 1'b1;
      idle(1);

      // Directed cases
      send(22'h0, 16'h1234, 16'h1234, 16'h1234, 1'b0);
      idle(3);
      set_key(5'b10000);
      d = m_desc(cur_k, 22'h0, 16'hAAAA);
      send(22'h0, 16'hAAAA, d, d, 1'b0);
      idle(3);
      set_key(5'b00000);
      send(22'h000001, 16'h1234, 16'h3412, 16'h3412, 1'b0);
      idle(4);
      chk("hold_dout", {16'd0, dout}, 32'h3412);
      chk("hold_mismatch", {31'd0, mismatch}, 32'd0);
      chk("err_cnt_directed", {16'd0, err_cnt}, 32'd0);

      // Random round trip with a fresh key loaded alongside every beat
      for (int i = 0; i < 2000; i++) begin
         a  = 22'($urandom);
         w  = 16'($urandom);
         kn = 5'($urandom);
         key_ld = 1'b1;
         key_in = kn;
         send(a, m_scr(cur_k, a, w), w, w, 1'b0);
         cur_k = kn;
      end
      idle(4);
      chk("roundtrip_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("roundtrip_sticky", {31'd0, err_sticky}, 32'd0);

      // Error accounting
      set_key(5'($urandom));
      w  = 16'($urandom);
      fg = m_desc(cur_k, 22'h00ABCD, w);
      send(22'h00ABCD, w, fg ^ 16'h0001, fg, 1'b1);
      w = 16'($urandom);
      d = m_desc(cur_k, 22'h001111, w);
      send(22'h001111, w, d ^ 16'h0100, d, 1'b1);
      idle(4);
      chk("err_cnt_two", {16'd0, err_cnt}, 32'd2);
      chk("sticky_two", {31'd0, err_sticky}, 32'd1);
      chk("first_addr_two", {10'd0, first_addr}, 32'h00ABCD);
      chk("first_got_two", {16'd0, first_got}, {16'd0, fg});

      w = 16'($urandom);
      d = m_desc(cur_k, 22'h002222, w);
      send(22'h002222, w, ~d, d, 1'b1);
      idle(1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      idle(3);
      chk("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("clr_sticky", {31'd0, err_sticky}, 32'd0);
      chk("clr_first_addr", {10'd0, first_addr}, 32'd0);
      chk("clr_first_got", {16'd0, first_got}, 32'd0);

      // Saturation
      fa = 22'($urandom);
      w  = 16'($urandom);
      fg = m_desc(cur_k, fa, w);
      send(fa, w, fg ^ 16'h8000, fg, 1'b1);
      for (int i = 1; i < 70000; i++) begin
         a = 22'($urandom);
         w = 16'($urandom);
         d = m_desc(cur_k, a, w);
         send(a, w, d ^ 16'h8000, d, 1'b1);
      end
      idle(4);
      chk("sat_err_cnt", {16'd0, err_cnt}, 32'hFFFF);
      chk("sat_sticky", {31'd0, err_sticky}, 32'd1);
      chk("sat_first_addr", {10'd0, first_addr}, {10'd0, fa});
      chk("sat_first_got", {16'd0, first_got}, {16'd0, fg});

      // Reset with beats in flight: neither beat may come out
      set_key(5'h1F);
      rd_valid = 1'b1; rd_addr = 22'h000123; rd_data = 16'h5A5A; exp_data = 16'h0;
      @(negedge clk);
      rd_addr = 22'h000456; rd_data = 16'hA5A5;
      rst_n = 1'b0;
      @(negedge clk);
      rd_valid = 1'b0;
      rst_n = 1'b1;
      cur_k = 5'h00;
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         if (dout_valid !== 1'b0) nv++;
         @(negedge clk);
      end
      chk("rst_flight_valids", nv, 32'd0);
      chk("rst_flight_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("rst_flight_sticky", {31'd0, err_sticky}, 32'd0);
      chk("rst_flight_first_addr", {10'd0, first_addr}, 32'd0);
      chk("rst_flight_first_got", {16'd0, first_got}, 32'd0);
      chk("rst_flight_dout", {16'd0, dout}, 32'd0);
      chk("rst_flight_mismatch", {31'd0, mismatch}, 32'd0);

      // Key must be back to zero: address 1 byte-swaps only with k=0
      send(22'h000001, 16'h1234, 16'h3412, 16'h3412, 1'b0);
      idle(4);
      chk("queue_drained", q_d.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
